// File: rtl/fp_div_issue_queue.sv
// fp_div_issue_queue
//   Issue/return wrapper around a fixed-latency pipelined FP divider.
//   Requests are forwarded to the divider as a registered one-cycle token.
//   Quotients come back tagged and are buffered in a show-ahead result FIFO.
//   Credits (used_count) cap outstanding plus buffered work at DEPTH, so a
//   returning quotient always has a FIFO slot.
//   After reset a FLUSH phase of LATENCY edges discards tokens that were
//   already inside the divider before reset.
//
// Ports
//   clock, reset_n                  clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_a, req_b, req_tag           operands and caller tag
//   div_token, div_a, div_b         divider trigger {tag, go} and operands
//   div_done_token, div_result      divider completion {tag, done} and quotient
//   resp_valid/resp_ready           response handshake
//   resp_result, resp_tag           FIFO head entry
//   used_count                      outstanding plus buffered requests
//   overflow_err                    sticky: done token arrived with FIFO full
module fp_div_issue_queue #(
  parameter int unsigned TAG_WIDTH = 4,
  parameter int unsigned LATENCY   = 14,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_a,
  input  logic [31:0]                  req_b,
  input  logic [TAG_WIDTH-1:0]         req_tag,
  output logic [TAG_WIDTH:0]           div_token,
  output logic [31:0]                  div_a,
  output logic [31:0]                  div_b,
  input  logic [TAG_WIDTH:0]           div_done_token,
  input  logic [31:0]                  div_result,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [31:0]                  resp_result,
  output logic [TAG_WIDTH-1:0]         resp_tag,
  output logic [$clog2(DEPTH+1)-1:0]   used_count,
  output logic                         overflow_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam int unsigned EW = TAG_WIDTH + 32;

  typedef enum logic [0:0] {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          state;
  logic [LW-1:0]   flush_cnt;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   fifo_cnt;
  logic [EW-1:0]   mem [DEPTH];

  logic accept;
  logic pop;
  logic done;
  logic fifo_full;
  logic wr;

  assign req_ready  = (state == RUN) && (used_count < CW'(DEPTH));
  assign accept     = req_valid && req_ready;
  assign resp_valid = (fifo_cnt != '0);
  assign pop        = resp_valid && resp_ready;
  assign done       = div_done_token[0] && (state == RUN);
  assign fifo_full  = (fifo_cnt == CW'(DEPTH));
  assign wr         = done && !fifo_full;

  assign {resp_tag, resp_result} = mem[rptr];

  // FLUSH lasts LATENCY edges so that anything issued before reset has
  // drained out of the divider before done tokens are accepted again.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FLUSH;
      flush_cnt <= LW'(LATENCY);
    end else if (state == FLUSH) begin
      if (flush_cnt <= LW'(1)) state <= RUN;
      if (flush_cnt != '0) flush_cnt <= flush_cnt - LW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_token <= '0;
      div_a     <= '0;
      div_b     <= '0;
    end else begin
      div_token <= accept ? {req_tag, 1'b1} : '0;
      if (accept) begin
        div_a <= req_a;
        div_b <= req_b;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      used_count <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   used_count <= used_count + CW'(1);
        2'b01:   used_count <= used_count - CW'(1);
        default: used_count <= used_count;
      endcase
    end
  end

  // Pointers are PW bits wide, so wrap modulo DEPTH is implicit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr         <= '0;
      rptr         <= '0;
      fifo_cnt     <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      case ({wr, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (done && fifo_full) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr) mem[wptr] <= {div_done_token[TAG_WIDTH:1], div_result};
  end

endmodule

// File: doc/fp_div_issue_queue.md
FP_DIV_ISSUE_QUEUE -- requirements
Module: fp_div_issue_queue

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 4: request tag width.
REQ-002 SHALL have parameter LATENCY, default 14: cycles from divider input sample to divider done output.
REQ-003 SHALL have parameter DEPTH, default 16: result FIFO entries and maximum outstanding requests; power of two, at least 2.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request may be accepted.
REQ-008 SHALL have ports req_a, req_b  input  32 each  IEEE-754 single-precision dividend and divisor.
REQ-009 SHALL have port req_tag  input  TAG_WIDTH  caller tag.
REQ-010 SHALL have port div_token  output  TAG_WIDTH+1  divider trigger: bit 0 is go, upper bits are tag.
REQ-011 SHALL have ports div_a, div_b  output  32 each  divider operands.
REQ-012 SHALL have port div_done_token  input  TAG_WIDTH+1  divider done trigger: bit 0 is done, upper bits are tag.
REQ-013 SHALL have port div_result  input  32  divider quotient.
REQ-014 SHALL have ports resp_valid  output  1, resp_ready  input  1, resp_result  output  32, resp_tag  output  TAG_WIDTH: response handshake.
REQ-015 SHALL have port used_count  output  clog2(DEPTH+1)  outstanding plus buffered requests.
REQ-016 SHALL have port overflow_err  output  1  sticky error flag.

Function
REQ-017 SHALL accept a request on a rising edge where req_valid and req_ready are both 1.
REQ-018 SHALL drive req_ready = (state == RUN) and (used_count < DEPTH), from registers only.
REQ-019 SHALL register div_token to {req_tag, 1} on the accept edge and to all-zeros on every other edge.
REQ-020 SHALL register div_a and div_b from req_a and req_b on accept, and hold them otherwise.
REQ-021 SHALL increment used_count on accept and decrement it on pop (resp_valid and resp_ready); when both occur on the same edge, used_count SHALL be unchanged.
REQ-022 SHALL write {div_done_token[TAG_WIDTH:1], div_result} into the FIFO on an edge where div_done_token[0] = 1 and state == RUN; a done token with bit 0 = 0 SHALL be ignored.
REQ-023 SHALL implement the FIFO with show-ahead behaviour: resp_valid = (fifo count != 0), and resp_result and resp_tag present the head entry.
REQ-024 SHALL wrap FIFO read and write pointers modulo DEPTH, and SHALL handle a simultaneous write and pop, including at count 0 and count DEPTH-1.
REQ-025 SHALL deliver responses in acceptance order; the latency from accept edge to first resp_valid high SHALL be exactly LATENCY+1 edges with resp_ready held high.
REQ-026 SHALL set overflow_err, and drop the write, if a done token arrives while the FIFO holds DEPTH entries; the credit rule guarantees this never occurs in correct operation.
REQ-027 SHALL implement a state machine with states FLUSH and RUN; FLUSH loads flush_cnt = LATENCY.
REQ-028 SHALL decrement flush_cnt each edge in FLUSH and enter RUN when it reaches 0; in FLUSH, req_ready = 0 and all done tokens SHALL be discarded.
REQ-029 SHALL pass operands through unmodified and perform no arithmetic; NaN, infinity and zero handling belong to the divider.

Reset
REQ-030 SHALL, while reset_n = 0, set state = FLUSH, flush_cnt = LATENCY, used_count = 0, FIFO pointers = 0, div_token = 0, div_a = 0, div_b = 0, overflow_err = 0, req_ready = 0 and resp_valid = 0.
REQ-031 SHALL apply reset asynchronously, including mid-operation; divider-resident tokens emerging afterwards SHALL be discarded under REQ-028.

Verification (LATENCY=14, DEPTH=16, TAG_WIDTH=4, bench divider model)
REQ-032 Bench SHALL check single request: after reset release, req_ready rises after 14 edges; accept a=0x40C00000, b=0x40000000, tag=3 -> resp_valid after 15 edges with resp_result=0x40400000, resp_tag=3.
REQ-033 Bench SHALL check backpressure: resp_ready=0 with 20 back-to-back requests -> exactly 16 accepted, req_ready=0, used_count=16, overflow_err=0; then drain yields tags in order.
REQ-034 Bench SHALL check simultaneous push and pop: used_count=5 with accept and pop on the same edge -> used_count stays 5 and the FIFO order is preserved.
REQ-035 Bench SHALL check reset mid-operation: 5 requests in flight, 1-cycle reset pulse -> no resp_valid for 14 edges, stale tokens dropped, used_count=0.
REQ-036 Bench SHALL check special values: 1.0/0.0 (0x3F800000, 0x00000000) -> resp_result=0x7F800000, and div_token=0 on every non-accept edge.
REQ-037 Bench SHALL check wrap: 40 requests with random resp_ready -> all 40 returned in order and overflow_err stays 0.
